envelope_line_buffer: RTL and testbench

//  Upstream stage of the CC3200 SPI link: captures one ultrasound line of envelope samples

---
 rtl/envelope_line_buffer.sv | 143 ++++++++++++++
 tb/tb_envelope_line_buffer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/envelope_line_buffer.sv
// Envelope line buffer: averages 2^Zoom envelope samples per byte into a line RAM
// and serves that RAM to the SPI slave through a registered read port.
`timescale 1ns/1ps
module envelope_line_buffer #(
  parameter int DEPTH       = 512,
  parameter int AW          = 9,
  parameter int SAMPLE_W    = 10,
  parameter int START_DELAY = 16
) (
  input  logic                Sys_Clk,
  input  logic                Sys_Rst_n,
  input  logic                Line_Trig,
  input  logic [SAMPLE_W-1:0] Sample_In,
  input  logic                Sample_Valid,
  input  logic [1:0]          Zoom,
  input  logic [AW-1:0]       Trans_Addr,
  output logic [7:0]          Trans_Data,
  output logic                Envelop,
  output logic                Line_Done,
  output logic                Trig_Miss
);
  localparam int ACC_W = SAMPLE_W + 3;
  localparam int DLY_W = $clog2(START_DELAY + 1);
  localparam logic [AW:0]      DEPTH_L   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]    LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [DLY_W-1:0] DLY_END   = DLY_W'(START_DELAY);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE, S_DONE} state_t;

  // Mean of the group, keeping the upper 8 of the SAMPLE_W significant bits.
  function automatic logic [7:0] avg_byte(input logic [ACC_W-1:0] acc,
                                          input logic [1:0]       zoom);
    return 8'(acc >> (32'(zoom) + SAMPLE_W - 8));
  endfunction

  state_t           state_q, state_d;
  logic [1:0]       zoom_q, zoom_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic [3:0]       grp_q, grp_d, grp_inc, grp_tgt;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic             rdy_q;
  logic             env_q, env_d;
  logic             done_q, done_d;
  logic             miss_q, miss_d;
  logic [7:0]       rd_q;
  logic             we;
  logic [7:0]       wdata;
  logic [7:0]       mem [DEPTH];

  always_comb begin
    state_d   = state_q;
    zoom_d    = zoom_q;
    dly_d     = dly_q;
    acc_d     = acc_q;
    grp_d     = grp_q;
    wr_addr_d = wr_addr_q;
    we        = 1'b0;
    acc_sum   = acc_q + {3'b000, Sample_In};
    grp_inc   = grp_q + 4'd1;
    grp_tgt   = 4'd1 << zoom_q;
    wdata     = avg_byte(acc_sum, zoom_q);
    miss_d    = Line_Trig && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        // rdy_q masks a trigger on the first edge after reset release.
        if (Line_Trig && rdy_q) begin
          state_d   = S_WAIT;
          zoom_d    = Zoom;
          dly_d     = '0;
          acc_d     = '0;
          grp_d     = '0;
          wr_addr_d = '0;
        end
      end
      S_WAIT: begin
        if (dly_q == DLY_END) state_d = S_CAPTURE;
        else                  dly_d   = dly_q + 1'b1;
      end
      S_CAPTURE: begin
        if (Sample_Valid) begin
          acc_d = acc_sum;
          grp_d = grp_inc;
          if (grp_inc == grp_tgt) begin
            we    = 1'b1;
            acc_d = '0;
            grp_d = '0;
            if (wr_addr_q == LAST_ADDR) state_d   = S_DONE;
            else                        wr_addr_d = wr_addr_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    env_d  = (state_d == S_WAIT) || (state_d == S_CAPTURE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge Sys_Clk or negedge Sys_Rst_n) begin
    if (!Sys_Rst_n) begin
      state_q   <= S_IDLE;
      zoom_q    <= '0;
      dly_q     <= '0;
      acc_q     <= '0;
      grp_q     <= '0;
      wr_addr_q <= '0;
      rdy_q     <= 1'b0;
      env_q     <= 1'b0;
      done_q    <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      zoom_q    <= zoom_d;
      dly_q     <= dly_d;
      acc_q     <= acc_d;
      grp_q     <= grp_d;
      wr_addr_q <= wr_addr_d;
      rdy_q     <= 1'b1;
      env_q     <= env_d;
      done_q    <= done_d;
      miss_q    <= miss_d;
    end
  end

  always_ff @(posedge Sys_Clk) begin
    if (we) mem[wr_addr_q] <= wdata;
  end

  // Read-before-write: a same-cycle read of the write address returns old data.
  always_ff @(posedge Sys_Clk or negedge Sys_Rst_n) begin
    if (!Sys_Rst_n)                         rd_q <= '0;
    else if ({1'b0, Trans_Addr} < DEPTH_L)  rd_q <= mem[Trans_Addr];
    else                                    rd_q <= '0;
  end

  assign Trans_Data = rd_q;
  assign Envelop    = env_q;
  assign Line_Done  = done_q;
  assign Trig_Miss  = miss_q;
endmodule

// File: tb/tb_envelope_line_buffer.sv
// Directed bench for envelope_line_buffer: a 512-byte build for capture, averaging,
// trigger handling and reset, plus a 400-byte build for out-of-range reads.
`timescale 1ns/1ps
module tb_envelope_line_buffer;
  logic       clk = 1'b0;
  logic       rst_n, trig, trig2, valid;
  logic [9:0] sample;
  logic [1:0] zoom;
  logic [8:0] addr, addr2;
  logic [7:0] data, data2;
  logic       env, done, miss, env2, done2, miss2;
  int         checks = 0;
  int         failures = 0;
  int         env_cnt, got;

  always #5 clk = ~clk;

  envelope_line_buffer u_dut (
    .Sys_Clk(clk), .Sys_Rst_n(rst_n), .Line_Trig(trig), .Sample_In(sample),
    .Sample_Valid(valid), .Zoom(zoom), .Trans_Addr(addr), .Trans_Data(data),
    .Envelop(env), .Line_Done(done), .Trig_Miss(miss));

  envelope_line_buffer #(.DEPTH(400)) u_d400 (
    .Sys_Clk(clk), .Sys_Rst_n(rst_n), .Line_Trig(trig2), .Sample_In(sample),
    .Sample_Valid(valid), .Zoom(zoom), .Trans_Addr(addr2), .Trans_Data(data2),
    .Envelop(env2), .Line_Done(done2), .Trig_Miss(miss2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] samp(input int mode, input int n);
    case (mode)
      0:       return 10'(n << 2);
      1:       return (n % 2 == 0) ? 10'h3FC : 10'h000;
      2:       return 10'h3FF;
      default: return 10'h200;
    endcase
  endfunction

  function automatic logic [7:0] exp_byte(input int mode, input int a);
    case (mode)
      0:       return 8'(a);
      1:       return 8'h7F;
      2:       return 8'hFF;
      default: return 8'h80;
    endcase
  endfunction

  // Triggers a line and feeds it; returns in the Line_Done cycle (or on timeout).
  // Junk samples are offered during WAIT and must be discarded.
  task automatic run_line(input int mode, input logic [1:0] z, input bit toggle,
                          input int miss_cyc, input bit zoom_chg,
                          output int env_cyc, output int seen);
    int n, cyc;
    n = 0; cyc = 0; env_cyc = 0; seen = 0;
    zoom = z; trig = 1'b1;
    tick();
    trig = 1'b0;
    while (seen == 0 && cyc < 20000) begin
      if (done) seen = 1;
      else begin
        if (env) env_cyc++;
        if (zoom_chg) zoom = ~z;
        trig = (cyc == miss_cyc);
        if (cyc < 17) begin
          valid  = 1'b1;
          sample = 10'h155;
        end else begin
          valid  = !toggle || (cyc % 2 == 1);
          sample = samp(mode, n);
          if (valid) n++;
        end
        tick();
        cyc++;
        if (cyc - 1 == miss_cyc) chk("trig_miss_busy", miss, 1);
      end
    end
    trig = 1'b0;
    valid = 1'b0;
    chk("line_done_seen", seen, 1);
  endtask

  task automatic read_all(input int mode, input string tag);
    for (int a = 0; a < 512; a++) begin
      addr = 9'(a);
      tick();
      chk(tag, data, exp_byte(mode, a));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; trig = 1'b0; trig2 = 1'b0; valid = 1'b0; sample = '0;
    zoom = '0; addr = '0; addr2 = '0;
    repeat (3) tick();
    chk("rst_envelop", env, 0);
    chk("rst_done", done, 0);
    chk("rst_miss", miss, 0);
    chk("rst_data", data, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_envelop", env, 0);

    // T1: abort mid-capture with reset; read during capture is live
    trig = 1'b1;
    tick();
    trig = 1'b0;
    chk("accept_envelop", env, 1);
    chk("accept_no_miss", miss, 0);
    valid = 1'b1; sample = 10'h3FF;
    repeat (30) tick();
    chk("t1_capturing", env, 1);
    addr = 9'd0;
    tick();
    chk("t1_read_during_capture", data, 8'hFF);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_async_envelop", env, 0);
    chk("t1_async_data", data, 0);
    chk("t1_async_done", done, 0);
    chk("t1_async_miss", miss, 0);
    valid = 1'b0;
    trig = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    trig = 1'b0;
    chk("t1_trig_at_release_env", env, 0);
    chk("t1_trig_at_release_miss", miss, 0);
    repeat (20) begin
      tick();
      chk("t1_no_done_after_abort", done, 0);
    end
    chk("t1_idle_env", env, 0);

    // T2: zoom 0, ramp samples
    run_line(0, 2'd0, 1'b0, -1, 1'b0, env_cnt, got);
    chk("t2_env_cycles", env_cnt, 529);
    chk("t2_env_low_in_done", env, 0);
    tick();
    chk("t2_done_one_cycle", done, 0);
    read_all(0, "t2_byte");

    // T3: zoom 2 with mid-line Zoom change
    run_line(1, 2'd2, 1'b0, -1, 1'b1, env_cnt, got);
    chk("t3_env_cycles", env_cnt, 2065);
    tick();
    read_all(1, "t3_byte");

    // T4: zoom 3, valid toggling
    run_line(2, 2'd3, 1'b1, -1, 1'b0, env_cnt, got);
    chk("t4_env_cycles", env_cnt, 8208);
    tick();
    read_all(2, "t4_byte");

    // T5: triggers while busy and in DONE, then accepted one cycle after DONE
    run_line(3, 2'd1, 1'b0, 100, 1'b0, env_cnt, got);
    chk("t5_env_cycles", env_cnt, 1041);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    chk("t5_miss_in_done", miss, 1);
    chk("t5_env_after_done", env, 0);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    chk("t5_accept_after_done", env, 1);
    chk("t5_no_miss_on_accept", miss, 0);
    repeat (50) tick();
    chk("t5_stall_env", env, 1);
    read_all(3, "t5_byte");
    chk("t5_stall_env_late", env, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_reset_env", env, 0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // T6: 400-byte build, out-of-range reads
    zoom = 2'd0;
    trig2 = 1'b1;
    tick();
    trig2 = 1'b0;
    valid = 1'b1; sample = 10'h3FF;
    env_cnt = 0; got = 0;
    for (int c = 0; c < 1000 && got == 0; c++) begin
      if (done2) got = 1;
      else begin
        if (env2) env_cnt++;
        tick();
      end
    end
    valid = 1'b0;
    chk("t6_done_seen", got, 1);
    chk("t6_env_cycles", env_cnt, 417);
    chk("t6_main_idle", env, 0);
    addr2 = 9'd399; tick(); chk("t6_addr399", data2, 8'hFF);
    addr2 = 9'd400; tick(); chk("t6_addr400", data2, 8'h00);
    addr2 = 9'd511; tick(); chk("t6_addr511", data2, 8'h00);
    addr2 = 9'd0;   tick(); chk("t6_addr0", data2, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
